// File: rtl/magnetron.sv
// magnetron - magnetron enable controller for the microwave-oven control path.
//
// A set/reset controller: a debounced start press sets it, and a debounced
// stop or clear press, an open door or an expired cook timer resets it.
// Every asynchronous input is synchronised first. The three buttons are also
// debounced. The raw door input gates the output directly, so opening the
// door drops the magnetron without waiting for a clock edge.
//
// Parameters:
//   SYNC_STAGES     - synchroniser depth per input (>= 2)
//   DEBOUNCE_CYCLES - consecutive differing samples before a button level
//                     is accepted (>= 1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rstn        in   asynchronous active-low reset
//   startn      in   start button, active low, asynchronous
//   stopn       in   stop/pause button, active low, asynchronous
//   clearn      in   clear button, active low, asynchronous
//   door_closed in   1 = door closed, asynchronous
//   timer_done  in   1 = cook timer expired, asynchronous
//   mag_on      out  1 = magnetron energised

module magnetron #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic startn,
    input  logic stopn,
    input  logic clearn,
    input  logic door_closed,
    input  logic timer_done,
    output logic mag_on
);

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1. The next
    // differing sample flips the filtered level instead of incrementing.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser bit order: {timer_done, door_closed, clearn, stopn, startn}.
    // Each bit resets to its inactive level. For the door, that level is
    // "open", which is the safe choice.
    localparam logic [4:0] SYNC_RESET = 5'b00111;

    typedef enum logic {
        IDLE    = 1'b0,
        COOKING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [4:0]                  sync_out;
    logic [2:0]                  btn_sync;
    logic                        door_sync;
    logic                        timer_sync;

    logic [2:0]                  filt_q, filt_d;
    logic [2:0][CNT_W-1:0]       cnt_q, cnt_d;

    logic                        set_term;
    logic                        rst_term;
    state_t                      state_q, state_d;

    // Shift chain: stage 0 samples the raw pins. The last stage feeds the
    // rest of the design.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {timer_done, door_closed, clearn, stopn, startn};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{SYNC_RESET}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign btn_sync   = sync_out[2:0];
    assign door_sync  = sync_out[3];
    assign timer_sync = sync_out[4];

    // Debounce: count consecutive samples that differ from the accepted
    // level. Any agreeing sample restarts the count, so a glitch has to be
    // held for the full window before it is accepted.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int b = 0; b < 3; b++) begin
            if (btn_sync[b] == filt_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                filt_d[b] = btn_sync[b];
                cnt_d[b]  = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_q <= 3'b111;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign set_term = !filt_q[0] && door_sync && !timer_sync;
    assign rst_term = !filt_q[1] || !filt_q[2] || !door_sync || timer_sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset terms dominate. Start is level-sensitive, so a held start button
    // re-enters COOKING as soon as every reset cause has cleared.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (set_term && !rst_term) state_d = COOKING;
            COOKING: if (rst_term)              state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The raw door pin is the interlock. It deliberately bypasses the
    // synchroniser.
    always_comb begin
        mag_on = (state_q == COOKING) && door_closed;
    end

endmodule

// File: tb/tb_magnetron.sv
// Testbench for magnetron. Stimulus pushes the expected mag_on level into a
// queue every cycle. A separate monitor pops that level and compares it.
// The reference model works on the history of raw samples: synchronised
// values are delayed raw samples, and a filtered button level flips when
// the last DEBOUNCE_CYCLES synchronised samples all disagree with it.

module tb_magnetron;

    localparam int S = 2;
    localparam int D = 4;
    // Vector order {timer_done, door_closed, clearn, stopn, startn}
    localparam logic [4:0] SYNC_RESET = 5'b00111;
    localparam logic [4:0] V_IDLE     = 5'b01111;
    localparam logic [4:0] V_START    = 5'b01110;

    logic clk;
    logic rstn;
    logic startn;
    logic stopn;
    logic clearn;
    logic door_closed;
    logic timer_done;
    logic mag_on;

    int checks = 0;
    int errors = 0;

    logic       exp_q[$];
    logic [4:0] raw_hist[$];
    logic [4:0] cur;
    logic [2:0] f_btn;
    logic       cook_m;
    bit         running;

    magnetron #(
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .startn(startn),
        .stopn(stopn),
        .clearn(clearn),
        .door_closed(door_closed),
        .timer_done(timer_done),
        .mag_on(mag_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed level against the expected level and record the result
    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: mag_on=%0b expected=%0b", name, $time, actual, expected);
        end
    endtask

    // Synchronised vector seen after edge j. Before the first edge it is the reset value.
    function automatic logic [4:0] synced(input int j);
        int i;
        i = j - S + 1;
        if (i < 1) return SYNC_RESET;
        return raw_hist[i-1];
    endfunction

    // Advance the model across the edge that just captured raw_hist's last entry
    task automatic advanceModel();
        int         n;
        logic [4:0] sp;
        logic [4:0] sk;
        logic       set_t;
        logic       rst_t;
        logic       all_diff;
        n     = raw_hist.size();
        sp    = synced(n - 1);
        set_t = !f_btn[0] && sp[3] && !sp[4];
        rst_t = !f_btn[1] || !f_btn[2] || !sp[3] || sp[4];
        if (rst_t)      cook_m = 1'b0;
        else if (set_t) cook_m = 1'b1;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int k = n - D; k <= n - 1; k++) begin
                sk = synced(k);
                if (sk[b] == f_btn[b]) all_diff = 1'b0;
            end
            if (all_diff) f_btn[b] = ~f_btn[b];
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expected output
    task automatic applyStimulus(input logic [4:0] v);
        @(negedge clk);
        if (running) begin
            raw_hist.push_back(cur);
            advanceModel();
        end
        cur         = v;
        startn      = v[0];
        stopn       = v[1];
        clearn      = v[2];
        door_closed = v[3];
        timer_done  = v[4];
        if (running) exp_q.push_back(cook_m && v[3]);
    endtask

    task automatic enterReset();
        rstn    = 1'b0;
        running = 1'b0;
        raw_hist.delete();
        f_btn   = 3'b111;
        cook_m  = 1'b0;
    endtask

    // Release the reset at a falling edge, away from the active edge
    task automatic releaseReset();
        @(negedge clk);
        rstn    = 1'b1;
        running = 1'b1;
        exp_q.push_back(cook_m && cur[3]);
    endtask

    // Hold a vector and check the output after each edge. A rising check
    // expects 1 from edge `edge_n` on. A falling check expects 0 from that edge on.
    task automatic runHold(input logic [4:0] v, input int cycles, input string name,
                           input int edge_n, input bit rising);
        applyStimulus(v);
        for (int k = 1; k <= cycles; k++) begin
            applyStimulus(v);
            #1;
            checkOutput(name, mag_on, rising ? (k >= edge_n) : (k < edge_n));
        end
    endtask

    // Scoreboard monitor: the output is a level, sampled once per cycle
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("scoreboard", mag_on, e);
            end
        end
    end

    initial begin
        logic [4:0] v;
        int         hold;

        cur         = V_IDLE;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;
        enterReset();

        // Reset held, then idle after release
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("reset_hold", mag_on, 1'b0);
        end
        releaseReset();
        runHold(V_IDLE, 8, "idle", 1000, 1'b1);

        // A short start pulse is filtered out
        applyStimulus(V_START);
        applyStimulus(V_START);
        runHold(V_IDLE, 10, "start_glitch", 1000, 1'b1);

        // Start held: rises on edge S+D+1
        runHold(V_START, 10, "start_latency", S + D + 1, 1'b1);

        // Stop and clear dominate a held start. Releasing them resumes cooking.
        runHold(5'b01100, 10, "stop_fall", S + D + 1, 1'b0);
        runHold(V_START, 10, "stop_release", S + D + 1, 1'b1);
        runHold(5'b01010, 10, "clear_fall", S + D + 1, 1'b0);
        runHold(V_START, 10, "clear_release", S + D + 1, 1'b1);

        // Door open drops the output without a clock edge
        applyStimulus(5'b00110);
        #1;
        checkOutput("door_comb", mag_on, 1'b0);
        runHold(5'b00110, 4, "door_open", 0, 1'b0);
        runHold(5'b00111, 10, "door_start_up", 1000, 1'b1);
        runHold(V_IDLE, 10, "door_reclose_idle", 1000, 1'b1);
        runHold(V_START, 10, "restart", S + D + 1, 1'b1);
        runHold(5'b00110, 8, "door_open_held", 0, 1'b0);
        runHold(V_START, 6, "door_reclose_start", S + 1, 1'b1);

        // The timer expiring stops cooking even with start held
        runHold(5'b11110, 12, "timer_fall", S + 1, 1'b0);
        runHold(V_START, 6, "timer_clear", S + 1, 1'b1);

        // An asynchronous reset mid-cook takes effect before the next edge
        @(posedge clk);
        #2;
        checkOutput("pre_async_reset", mag_on, 1'b1);
        enterReset();
        #1;
        checkOutput("async_reset", mag_on, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("async_reset_hold", mag_on, 1'b0);
        releaseReset();

        // Randomised segments of held input patterns
        for (int seg = 0; seg < 60; seg++) begin
            v[0] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 5) != 0);
            v[2] = ($urandom_range(0, 5) != 0);
            v[3] = ($urandom_range(0, 7) != 0);
            v[4] = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 12);
            for (int c = 0; c < hold; c++) begin
                applyStimulus(v);
            end
        end

        repeat (2) @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/magnetron.md
# magnetron

Magnetron enable controller for the microwave-oven control path. It takes the active-low front-panel buttons, the door interlock and the cook-timer expiry flag, and drives `mag_on`, the enable for the magnetron power stage. The block is a synchronous set/reset controller: start sets it, and stop, clear, door-open or timer-done reset it. It adds input synchronisation, button debouncing and a combinational door interlock on the output.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser; legal values ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronised samples required before a button level is accepted; applies to `startn`, `stopn` and `clearn`; legal values ≥ 1.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `startn`  in  1  start button, active low, asynchronous to `clk`.
- `stopn`  in  1  stop/pause button, active low, asynchronous.
- `clearn`  in  1  clear button, active low, asynchronous.
- `door_closed`  in  1  1 = door closed, asynchronous.
- `timer_done`  in  1  1 = cook timer expired, asynchronous.
- `mag_on`  out  1  1 = magnetron energised.

## Operation
- Input synchronisers:
  - Every input passes through a `SYNC_STAGES`-deep synchroniser.
  - Synchroniser flops reset to the inactive or safe level: `startn`/`stopn`/`clearn` = 1, `door_closed` = 0, `timer_done` = 0.
- Debounce (buttons only):
  - Each synchronised button has a counter.
  - The filtered level changes only after the synchronised value has differed from the current filtered level for `DEBOUNCE_CYCLES` consecutive samples.
  - Any sample equal to the filtered level clears the counter.
  - Filtered levels reset to 1 (not pressed).
  - `door_closed` and `timer_done` are not debounced.
- Derived terms:
  - set = filtered start pressed AND synced `door_closed` = 1 AND synced `timer_done` = 0.
  - rst = filtered stop pressed OR filtered clear pressed OR synced `door_closed` = 0 OR synced `timer_done` = 1.
- State machine, two states, one register `cooking`:
  - IDLE (`cooking` = 0): go to COOKING when set AND NOT rst.
  - COOKING (`cooking` = 1): go to IDLE when rst; otherwise stay.
  - Reset has priority over set. Simultaneous start and stop/clear/door-open/timer-done leaves or keeps the block in IDLE.
  - Start is level-sensitive. If `startn` is still held low when the reset cause is removed, the block re-enters COOKING without a new press.
- Output: `mag_on` = `cooking` AND raw `door_closed`.
  - The raw door input gates the output combinationally as a safety interlock.
  - Opening the door drops `mag_on` immediately, independent of `clk`.
- `rstn` low: all registers return to their reset values at once; `mag_on` = 0. Asserting `rstn` mid-cook stops cooking immediately.

## Timing
- Reset values: `cooking` = 0, `mag_on` = 0, all debounce counters = 0.
- Start latency: from a stable `startn` = 0 (with door closed and timer not done, both already settled), `mag_on` rises on the (`SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1)th rising edge. With defaults this is the 7th edge.
- Stop/clear latency: `mag_on` falls on edge `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 after the button is asserted. Defaults: 7.
- Timer-done latency: `mag_on` falls on edge `SYNC_STAGES` + 1. Defaults: 3.
- Door open:
  - `mag_on` falls combinationally, with zero cycles of latency.
  - `cooking` clears on edge `SYNC_STAGES` + 1.
  - After the door recloses, `mag_on` stays low until `cooking` is set again by start.
- Button glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles have no effect.
- There is no handshake; the output is a level.

## Test plan
- Reset/idle: hold `rstn` = 0, then release with all buttons high, `door_closed` = 1, `timer_done` = 0 → `mag_on` = 0 throughout.
- Start:
  - `startn` = 0 held, door closed, timer not done → `mag_on` = 1 exactly 7 edges later (defaults).
  - A 2-cycle `startn` pulse → `mag_on` stays 0.
- Stop/clear priority:
  - While cooking, `stopn` = 0 (with `startn` still low) → `mag_on` = 0 after 7 edges.
  - Release `stopn` → `mag_on` returns to 1 after 7 edges.
  - Repeat the same sequence with `clearn`.
- Door interlock:
  - While cooking, `door_closed` = 0 → `mag_on` = 0 in the same delta cycle.
  - Reclose the door with `startn` high → `mag_on` stays 0.
  - Reclose the door with `startn` low → `mag_on` = 1 after `SYNC_STAGES` + 1 edges.
- Timer done: while cooking, `timer_done` = 1 → `mag_on` = 0 after 3 edges; `mag_on` stays 0 while `timer_done` = 1 even with `startn` = 0.
- Async reset mid-cook: `rstn` = 0 while cooking → `mag_on` = 0 immediately, before the next `clk` edge.
